// File: rtl/router_xy_port.sv
// ---------------------------------------------------------------------------
// router_xy_port
//   Input port of a 2D-mesh NoC router. Incoming AXI-stream beats are
//   buffered in a small FIFO. The header beat of each packet is routed
//   dimension-ordered (X first, then Y) relative to this router's
//   coordinates, and the whole packet is forwarded through a one-entry
//   output register to one of five directions. Packets whose destination
//   lies outside the mesh are consumed and discarded, and drop pulses once.
//
//   tdata layout, MSB->LSB: {src_x, src_y, dst_x, dst_y, mtype, data}
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_x, cfg_y             this router's coordinates (static after reset)
//   s_tvalid/s_tready/s_tdata/s_tlast   input stream
//   m_tvalid[4:0]            per-direction valid: [0]E [1]W [2]N [3]S [4]LOCAL
//   m_tready[4:0]            per-direction ready
//   m_tdata, m_tlast         output beat shared by all directions
//   drop                     pulse in the cycle a bad header is popped
//
// Optional feature (macro ROUTER_PORT_STATS_EN)
//   stat_pkt_cnt[5*CNT_W]    per-direction forwarded-packet counters (wrap)
//   stat_drop_cnt[CNT_W]     dropped-packet counter (wraps)
// ---------------------------------------------------------------------------
module router_xy_port #(
   parameter int BUS_W   = 64,
   parameter int COORD_W = 4,
   parameter int MTYPE_W = 8,
   parameter int DEPTH   = 4,
   parameter int MESH_X  = 16,
   parameter int MESH_Y  = 16,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] cfg_x,
   input  logic [COORD_W-1:0] cfg_y,
   input  logic               s_tvalid,
   output logic               s_tready,
   input  logic [BUS_W-1:0]   s_tdata,
   input  logic               s_tlast,
   output logic [4:0]         m_tvalid,
   input  logic [4:0]         m_tready,
   output logic [BUS_W-1:0]   m_tdata,
   output logic               m_tlast,
   output logic               drop
`ifdef ROUTER_PORT_STATS_EN
   ,
   output logic [5*CNT_W-1:0] stat_pkt_cnt,
   output logic [CNT_W-1:0]   stat_drop_cnt
`endif
);

   localparam int DATA_W = BUS_W - 4*COORD_W - MTYPE_W;
   localparam int DY_LSB = DATA_W + MTYPE_W;
   localparam int DX_LSB = DY_LSB + COORD_W;
   localparam int PTR_W  = $clog2(DEPTH);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   // One extra bit so MESH_X = 2**COORD_W is representable.
   localparam logic [COORD_W:0] MESH_X_L = (COORD_W+1)'(MESH_X);
   localparam logic [COORD_W:0] MESH_Y_L = (COORD_W+1)'(MESH_Y);

   localparam logic [2:0] P_E = 3'd0;
   localparam logic [2:0] P_W = 3'd1;
   localparam logic [2:0] P_N = 3'd2;
   localparam logic [2:0] P_S = 3'd3;
   localparam logic [2:0] P_L = 3'd4;

   typedef enum logic [1:0] {ST_HEAD, ST_BODY, ST_DROP} state_t;

   // ---------------- input FIFO ----------------
   logic [BUS_W:0]   fifo_mem [DEPTH];   // {last, data}
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign full     = (count_reg == FULL_CNT);
   assign empty    = (count_reg == '0);
   assign s_tready = ~full & ~rst;
   assign push     = s_tvalid & s_tready;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {s_tlast, s_tdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop)      count_reg <= count_reg + 1'b1;
         else if (pop && !push) count_reg <= count_reg - 1'b1;
      end
   end

   // ---------------- FIFO head decode ----------------
   logic [BUS_W:0]     head;
   logic [BUS_W-1:0]   head_data;
   logic               head_last;
   logic [COORD_W-1:0] dst_x;
   logic [COORD_W-1:0] dst_y;
   logic               bad_dst;
   logic [2:0]         route_port;

   assign head      = fifo_mem[rd_ptr_reg];
   assign head_data = head[BUS_W-1:0];
   assign head_last = head[BUS_W];
   assign dst_x     = head_data[DX_LSB +: COORD_W];
   assign dst_y     = head_data[DY_LSB +: COORD_W];
   assign bad_dst   = ({1'b0, dst_x} >= MESH_X_L) || ({1'b0, dst_y} >= MESH_Y_L);

   // X is resolved completely before Y is considered.
   always_comb begin
      route_port = P_L;
      if (dst_x > cfg_x)      route_port = P_E;
      else if (dst_x < cfg_x) route_port = P_W;
      else if (dst_y > cfg_y) route_port = P_N;
      else if (dst_y < cfg_y) route_port = P_S;
   end

   // ---------------- output register ----------------
   logic             out_valid_reg;
   logic [BUS_W-1:0] out_data_reg;
   logic             out_last_reg;
   logic [2:0]       out_port_reg;
   logic             drain;
   logic             out_free;

   assign drain    = out_valid_reg & m_tready[out_port_reg];
   assign out_free = ~out_valid_reg | drain;

   // ---------------- packet FSM ----------------
   state_t     state_reg;
   state_t     state_next;
   logic [2:0] port_reg;
   logic [2:0] port_next;
   logic       load;
   logic       drop_hdr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_HEAD;
         port_reg  <= P_L;
      end else begin
         state_reg <= state_next;
         port_reg  <= port_next;
      end
   end

   // Dropped beats bypass the output register, so they pop regardless of it.
   always_comb begin
      state_next = state_reg;
      port_next  = port_reg;
      pop        = 1'b0;
      load       = 1'b0;
      drop_hdr   = 1'b0;
      if (!rst && !empty) begin
         case (state_reg)
            ST_HEAD: begin
               if (bad_dst) begin
                  pop      = 1'b1;
                  drop_hdr = 1'b1;
                  if (!head_last) state_next = ST_DROP;
               end else if (out_free) begin
                  pop       = 1'b1;
                  load      = 1'b1;
                  port_next = route_port;
                  if (!head_last) state_next = ST_BODY;
               end
            end
            ST_BODY: begin
               if (out_free) begin
                  pop  = 1'b1;
                  load = 1'b1;
                  if (head_last) state_next = ST_HEAD;
               end
            end
            ST_DROP: begin
               pop = 1'b1;
               if (head_last) state_next = ST_HEAD;
            end
            default: state_next = ST_HEAD;
         endcase
      end
   end

   assign drop = drop_hdr;

   // The header's port is taken straight from the route so it does not wait
   // for port_reg to update; body beats reuse the latched port.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_port_reg  <= P_L;
      end else if (load) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= head_data;
         out_last_reg  <= head_last;
         out_port_reg  <= (state_reg == ST_HEAD) ? route_port : port_reg;
      end else if (drain) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign m_tdata = out_data_reg;
   assign m_tlast = out_last_reg;

   for (genvar gi = 0; gi < 5; gi++) begin : g_valid
      assign m_tvalid[gi] = out_valid_reg && (out_port_reg == 3'(gi));
   end

`ifdef ROUTER_PORT_STATS_EN
   // ---------------- statistics ----------------
   for (genvar gi = 0; gi < 5; gi++) begin : g_stat
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg <= '0;
         end else if (drain && out_last_reg && (out_port_reg == 3'(gi))) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
      assign stat_pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
   end

   logic [CNT_W-1:0] drop_cnt_reg;
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_reg <= '0;
      end else if (drop_hdr) begin
         drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
   end
   assign stat_drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_router_xy_port.sv
// ---------------------------------------------------------------------------
// tb_router_xy_port
//   Directed and randomized bench for router_xy_port. Packets are built at
//   packet level; the expected output stream (beat, last, direction) and
//   the expected number of drops are derived from the XY routing rules and
//   compared against every output handshake by a monitor.
// ---------------------------------------------------------------------------
module tb_router_xy_port;

   localparam int BUS_W   = 64;
   localparam int COORD_W = 4;
   localparam int MTYPE_W = 8;
   localparam int DEPTH   = 4;
   localparam int MESH_X  = 8;
   localparam int MESH_Y  = 8;
   localparam int CNT_W   = 2;

   logic             clk;
   logic             rst;
   logic [3:0]       cfg_x;
   logic [3:0]       cfg_y;
   logic             s_tvalid;
   logic             s_tready;
   logic [63:0]      s_tdata;
   logic             s_tlast;
   logic [4:0]       m_tvalid;
   logic [4:0]       m_tready;
   logic [63:0]      m_tdata;
   logic             m_tlast;
   logic             drop;
`ifdef ROUTER_PORT_STATS_EN
   logic [5*CNT_W-1:0] stat_pkt_cnt;
   logic [CNT_W-1:0]   stat_drop_cnt;
`endif

   router_xy_port #(
      .BUS_W(BUS_W), .COORD_W(COORD_W), .MTYPE_W(MTYPE_W), .DEPTH(DEPTH),
      .MESH_X(MESH_X), .MESH_Y(MESH_Y), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_x(cfg_x), .cfg_y(cfg_y),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .drop(drop)
`ifdef ROUTER_PORT_STATS_EN
      , .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic        l;
      int          p;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   exp_drops = 0;
   int   drop_seen = 0;
   int   cur_cx = 0;
   int   cur_cy = 0;
   bit   rand_rdy = 0;

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Direction index from the XY rule: 0 E, 1 W, 2 N, 3 S, 4 LOCAL.
   function automatic int route(input int dx, input int dy, input int cx, input int cy);
      if (dx > cx) return 0;
      if (dx < cx) return 1;
      if (dy > cy) return 2;
      if (dy < cy) return 3;
      return 4;
   endfunction

   function automatic logic [63:0] mk_hdr(input int dx, input int dy);
      logic [63:0] h;
      h = {$urandom, $urandom};
      h[55:52] = 4'(dx);
      h[51:48] = 4'(dy);
      return h;
   endfunction

   // ---------------- output monitor ----------------
   logic        prev_pend = 1'b0;
   logic [4:0]  prev_v;
   logic [63:0] prev_d;
   logic        prev_l;

   always @(negedge clk) begin
      if (rst) begin
         prev_pend = 1'b0;
      end else begin
         if (drop) drop_seen++;
         chk("onehot", 128'($onehot0(m_tvalid)), 128'(1));
         if (prev_pend) begin
            chk("hold_valid", 128'(m_tvalid), 128'(prev_v));
            chk("hold_data", 128'(m_tdata), 128'(prev_d));
            chk("hold_last", 128'(m_tlast), 128'(prev_l));
         end
         if ((m_tvalid & m_tready) != 5'd0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 128'(m_tvalid), 128'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_beat", {59'd0, m_tvalid, m_tlast, m_tdata},
                   {59'd0, 5'(5'd1 << e.p), e.l, e.d});
            end
         end
         prev_pend = (m_tvalid != 5'd0) && ((m_tvalid & m_tready) == 5'd0);
         prev_v = m_tvalid;
         prev_d = m_tdata;
         prev_l = m_tlast;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called and returns at posedge+1.
   task automatic feed_one(input logic [63:0] d, input logic l);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         n++;
         if (rand_rdy) m_tready = 5'($urandom);
      end
      s_tvalid = 1'b0;
      chk("feed_accept", 128'(acc), 128'(1));
   endtask

   task automatic send_pkt(input int dx, input int dy, input int len, input bit poison);
      logic [63:0] b;
      bit          bad_d;
      int          p;
      bad_d = (dx >= MESH_X) || (dy >= MESH_Y);
      p = route(dx, dy, cur_cx, cur_cy);
      for (int i = 0; i < len; i++) begin
         if (i == 0) begin
            b = mk_hdr(dx, dy);
         end else begin
            b = {$urandom, $urandom};
            if (poison) b[55:48] = 8'h99;
         end
         if (!bad_d) exp_q.push_back('{d: b, l: (i == len - 1), p: p});
         feed_one(b, (i == len - 1));
      end
      if (bad_d) exp_drops++;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
         if (rand_rdy) m_tready = 5'($urandom);
      end
      m_tready = 5'h1f;
      repeat (4) @(posedge clk);
      #1;
      chk("drain_empty", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic do_reset(input int cx, input int cy);
      rst = 1'b1;
      s_tvalid = 1'b0;
      cur_cx = cx;
      cur_cy = cy;
      cfg_x = 4'(cx);
      cfg_y = 4'(cy);
      exp_q.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_tready", 128'(s_tready), 128'(0));
      chk("rst_outs", {63'd0, m_tvalid, m_tlast, drop, m_tdata}, 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_drops = 0;
      drop_seen = 0;
      @(negedge clk);
      chk("post_rst_tready", 128'(s_tready), 128'(1));
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] beats [8];
      int          idx;
      logic        acc;

      rst = 1'b1;
      s_tvalid = 1'b0;
      s_tdata = '0;
      s_tlast = 1'b0;
      m_tready = 5'h1f;
      cfg_x = '0;
      cfg_y = '0;

      // Single-beat routing and two-cycle latency at cfg (3,3).
      do_reset(3, 3);
      send_pkt(5, 1, 1, 0);
      @(negedge clk);
      chk("lat_early_E", 128'(m_tvalid), 128'(0));
      @(negedge clk);
      chk("lat_E", 128'(m_tvalid), 128'(5'b00001));
      @(posedge clk); #1;
      send_pkt(3, 0, 1, 0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_S", 128'(m_tvalid), 128'(5'b01000));
      @(posedge clk); #1;
      send_pkt(3, 3, 1, 0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_L", 128'(m_tvalid), 128'(5'b10000));
      @(posedge clk); #1;
      wait_drain();

      // Four-beat packet to W; body beats carry out-of-mesh coordinates.
      send_pkt(1, 7, 4, 1);
      wait_drain();
      chk("drops_none", 128'(drop_seen), 128'(0));

      // Backpressure: five beats fit (FIFO plus output register).
      m_tready = 5'h00;
      beats[0] = mk_hdr(7, 3);
      for (int i = 1; i < 8; i++) beats[i] = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) exp_q.push_back('{d: beats[i], l: (i == 7), p: 0});
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         s_tvalid = 1'b1;
         s_tdata = beats[idx];
         s_tlast = (idx == 7);
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         if (acc) idx++;
      end
      s_tvalid = 1'b0;
      chk("bp_accepted", 128'(idx), 128'(5));
      @(negedge clk);
      chk("bp_tready_low", 128'(s_tready), 128'(0));
      chk("bp_valid_held", 128'(m_tvalid), 128'(5'b00001));
      @(posedge clk); #1;
      m_tready = 5'h1f;
      while (idx < 8) begin
         feed_one(beats[idx], (idx == 7));
         idx++;
      end
      wait_drain();

      // Bad destination dropped, following packet still routed.
      do_reset(2, 2);
      send_pkt(9, 0, 3, 0);
      send_pkt(0, 0, 1, 0);
      wait_drain();
      chk("drop_count", 128'(drop_seen), 128'(1));

      // Reset in the middle of a 6-beat packet.
      do_reset(3, 3);
      m_tready = 5'h00;
      feed_one(mk_hdr(1, 3), 1'b0);
      feed_one({$urandom, $urandom}, 1'b0);
      feed_one({$urandom, $urandom}, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_outs", {63'd0, m_tvalid, m_tlast, drop, m_tdata}, 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      m_tready = 5'h1f;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_quiet", 128'(m_tvalid), 128'(0));
      end
      @(posedge clk); #1;
      send_pkt(3, 3, 1, 0);
      wait_drain();

      // Randomized packets, destinations and backpressure.
      do_reset(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      rand_rdy = 1;
      for (int k = 0; k < 40; k++) begin
         send_pkt(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(1, 4)), 0);
      end
      wait_drain();
      rand_rdy = 0;
      chk("rand_drops", 128'(drop_seen), 128'(exp_drops));

`ifdef ROUTER_PORT_STATS_EN
      do_reset(3, 3);
      for (int k = 0; k < 5; k++) send_pkt(3, 7, 1, 0);
      send_pkt(9, 9, 2, 0);
      wait_drain();
      chk("stat_north", 128'(stat_pkt_cnt[2*CNT_W +: CNT_W]), 128'(1));
      chk("stat_east", 128'(stat_pkt_cnt[0 +: CNT_W]), 128'(0));
      chk("stat_drop", 128'(stat_drop_cnt), 128'(1));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
